rom_boot_loader: RTL

// - Upstream stage of the simpleCPU: receives a program image as an 8-bit byte stream (UART RX / host

---
 rtl/rom_boot_loader.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/rom_boot_loader.sv
// rom_boot_loader: receives a framed program image on an 8-bit byte stream
// and writes it as 9-bit instructions into the program ROM write port.
// The CPU is held in reset while a frame is in progress and is released
// only after a complete frame with a good checksum.
//
// Frame: 0xA5, LEN_HI, LEN_LO, N x {INSTR_LO, INSTR_HI (bit0 = instr[8])}, CHK
// CHK is the 8-bit XOR of LEN_HI, LEN_LO and all data bytes.
//
// Byte handshake: a byte is consumed on a rising clock edge where both
// i_rx_valid and o_rx_ready are high. o_rx_ready is registered and drops for
// exactly the one WRITE cycle per instruction. The source must hold an
// unconsumed byte stable.
//
// Optional build macro LOADER_TIMEOUT_EN: when defined, a frame that sees
// g_TIMEOUT consecutive cycles without an accepted byte is aborted to ERROR.
// When undefined, the loader waits for bytes indefinitely.
//
// o_dbg_state exposes the current FSM state for checkers.
module rom_boot_loader #(
  parameter int g_ROM_WIDTH    = 9,
  parameter int g_ROM_ADDR     = 11,
  parameter int g_RUN_AT_RESET = 0,
  parameter int g_TIMEOUT      = 100000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_rx_valid,
  input  logic [7:0]             i_rx_data,
  output logic                   o_rx_ready,
  output logic                   o_rom_we,
  output logic [g_ROM_ADDR-1:0]  o_rom_addr,
  output logic [g_ROM_WIDTH-1:0] o_rom_data,
  output logic                   o_cpu_rst,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic [3:0]             o_dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LEN_HI = 4'd1,
    S_LEN_LO = 4'd2,
    S_D_LO   = 4'd3,
    S_D_HI   = 4'd4,
    S_WRITE  = 4'd5,
    S_CHK    = 4'd6,
    S_DONE   = 4'd7,
    S_ERROR  = 4'd8
  } state_t;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  // Largest legal instruction count: the whole ROM.
  localparam logic [16:0] MAX_N     = 17'(1) << g_ROM_ADDR;
  localparam logic        CPU_RST_INIT = (g_RUN_AT_RESET == 0);

  state_t                   state_q, state_d;
  logic                     rx_ready_q, rx_ready_d;
  logic                     rom_we_q, rom_we_d;
  logic [g_ROM_ADDR-1:0]    rom_addr_q, rom_addr_d;
  logic [g_ROM_WIDTH-1:0]   rom_data_q, rom_data_d;
  logic                     cpu_rst_q, cpu_rst_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic [7:0]               len_hi_q, len_hi_d;
  logic [g_ROM_ADDR:0]      n_q, n_d;
  logic [g_ROM_ADDR:0]      count_q, count_d;
  logic [7:0]               chk_q, chk_d;
  logic [7:0]               lo_q, lo_d;

  logic                     accept;
  logic [15:0]              len_full;
  logic                     in_frame;

  assign accept   = i_rx_valid & rx_ready_q;
  assign len_full = {len_hi_q, i_rx_data};
  // Frame-in-progress states (LEN_HI through CHK).
  assign in_frame = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(g_TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d    = state_q;
    rom_we_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    rom_data_d = rom_data_q;
    cpu_rst_d  = cpu_rst_q;
    done_d     = done_q;
    err_d      = err_q;
    len_hi_d   = len_hi_q;
    n_d        = n_q;
    count_d    = count_q;
    chk_d      = chk_q;
    lo_d       = lo_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        // Non-sync bytes are consumed and dropped.
        if (accept && (i_rx_data == SYNC_BYTE)) begin
          state_d    = S_LEN_HI;
          chk_d      = '0;
          count_d    = '0;
          rom_addr_d = '0;
          cpu_rst_d  = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_hi_d = i_rx_data;
          chk_d    = chk_q ^ i_rx_data;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          chk_d = chk_q ^ i_rx_data;
          n_d   = len_full[g_ROM_ADDR:0];
          if ({1'b0, len_full} > MAX_N) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else if (len_full == 16'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_D_LO;
          end
        end
      end
      S_D_LO: begin
        if (accept) begin
          lo_d    = i_rx_data;
          chk_d   = chk_q ^ i_rx_data;
          state_d = S_D_HI;
        end
      end
      S_D_HI: begin
        if (accept) begin
          chk_d = chk_q ^ i_rx_data;
          if (i_rx_data[7:1] != 7'd0) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else begin
            // Strobe, address and data appear together in the WRITE cycle.
            state_d    = S_WRITE;
            rom_we_d   = 1'b1;
            rom_addr_d = count_q[g_ROM_ADDR-1:0];
            rom_data_d = {i_rx_data[0], lo_q};
          end
        end
      end
      S_WRITE: begin
        count_d = count_q + 1'b1;
        state_d = (count_d == n_q) ? S_CHK : S_D_LO;
      end
      S_CHK: begin
        if (accept) begin
          if (i_rx_data == chk_q) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef LOADER_TIMEOUT_EN
    tmo_d = tmo_q;
    if (accept) begin
      tmo_d = '0;
    end else if (in_frame) begin
      if (tmo_q == TW'(g_TIMEOUT - 1)) begin
        state_d  = S_ERROR;
        err_d    = 1'b1;
        done_d   = 1'b0;
        rom_we_d = 1'b0;
        tmo_d    = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif

    rx_ready_d = (state_d != S_WRITE);
    busy_d     = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERROR);
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      rx_ready_q <= 1'b0;
      rom_we_q   <= 1'b0;
      rom_addr_q <= '0;
      rom_data_q <= '0;
      cpu_rst_q  <= CPU_RST_INIT;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      len_hi_q   <= '0;
      n_q        <= '0;
      count_q    <= '0;
      chk_q      <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_ready_d;
      rom_we_q   <= rom_we_d;
      rom_addr_q <= rom_addr_d;
      rom_data_q <= rom_data_d;
      cpu_rst_q  <= cpu_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      len_hi_q   <= len_hi_d;
      n_q        <= n_d;
      count_q    <= count_d;
      chk_q      <= chk_d;
      lo_q       <= lo_d;
    end
  end

`ifdef LOADER_TIMEOUT_EN
  // Inter-byte idle counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign o_rx_ready  = rx_ready_q;
  assign o_rom_we    = rom_we_q;
  assign o_rom_addr  = rom_addr_q;
  assign o_rom_data  = rom_data_q;
  assign o_cpu_rst   = cpu_rst_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_dbg_state = state_q;

endmodule
